// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered UART transmitter with configurable word width, parity
//            and stop bits. Optional line-break support via UART_TX_BREAK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          Tx_rst,
`ifdef UART_TX_BREAK_EN
    input  logic                          break_req,
`endif
    input  logic                          wr_en,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          done,
    output logic                          transfere_data
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int c_BIT_W  = $clog2(DATA_BITS);

    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_PRE  = c_BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_overflow;

    logic [2:0]           r_state;
    logic [c_BAUD_W-1:0]  r_baud;
    logic [c_BIT_W-1:0]   r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_line;
    logic                 r_done;
    logic                 r_busy;

    logic                 w_brk;
    logic                 w_brk_hold;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

`ifdef UART_TX_BREAK_EN
    // The extra registered copy keeps the line high for one cycle after a
    // break is released before the next start bit is allowed.
    logic r_brk_prev;

    always_ff @(posedge clk) begin
        if (Tx_rst) r_brk_prev <= 1'b0;
        else        r_brk_prev <= break_req;
    end

    assign w_brk      = break_req;
    assign w_brk_hold = break_req | r_brk_prev;
`else
    assign w_brk      = 1'b0;
    assign w_brk_hold = 1'b0;
`endif

    assign full       = (r_count == c_FULL);
    assign empty      = (r_count == '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

    assign w_push     = wr_en & ~full;
    assign w_pop      = (r_state == c_IDLE) & ~empty & ~w_brk_hold;
    assign w_baud_end = (r_baud == c_BAUD_LAST);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_par = (PARITY_MODE == 2) ? ~(^w_head) : ^w_head;

    always_ff @(posedge clk) begin
        if (!Tx_rst && w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (Tx_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)         r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (w_pop)          r_rd_ptr   <= r_rd_ptr + 1'b1;
            if (wr_en && full)  r_overflow <= 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (Tx_rst) begin
            r_state <= c_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_line  <= 1'b1;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_par   <= w_head_par;
                        r_state <= c_START;
                        r_line  <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_line  <= ~w_brk;
                    end
                end
                c_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= c_DATA;
                        r_line  <= r_shift[0];
                    end else begin
                        r_baud  <= r_baud + 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == c_BIT_LAST) begin
                            r_bit <= '0;
                            if (PARITY_MODE != 0) begin
                                r_state <= c_PARITY;
                                r_line  <= r_par;
                            end else begin
                                r_state <= c_STOP;
                                r_line  <= 1'b1;
                            end
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_line  <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_PARITY: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= c_STOP;
                        r_line  <= 1'b1;
                    end else begin
                        r_baud  <= r_baud + 1'b1;
                    end
                end
                c_STOP: begin
                    // done is raised one cycle early so it lines up with the
                    // final stop-bit cycle rather than the following idle one.
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == c_STOP_LAST) begin
                            r_state <= c_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                        r_done <= (r_baud == c_BAUD_PRE) && (r_bit == c_STOP_LAST);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_line  <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign transfere_data = r_line;
    assign done           = r_done;
    assign busy           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Self-checking bench for uart_tx_fifo; three parity/stop variants
//            compared cycle by cycle against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int NI    = 3;
    localparam int DB    = 8;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          Tx_rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DB-1:0] wr_data = '0;
`ifdef UART_TX_BREAK_EN
    logic          break_req = 1'b0;
`endif

    logic [NI-1:0] full, empty, overflow, busy, done, line;
    logic [CW-1:0] fifo_count [NI];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            uart_tx_fifo #(
                .DATA_BITS   (DB),
                .CLKS_PER_BIT(CPB),
                .FIFO_DEPTH  (DEPTH),
                .PARITY_MODE (gi),
                .STOP_BITS   ((gi == 1) ? 2 : 1)
            ) u_dut (
                .clk           (clk),
                .Tx_rst        (Tx_rst),
`ifdef UART_TX_BREAK_EN
                .break_req     (break_req),
`endif
                .wr_en         (wr_en),
                .wr_data       (wr_data),
                .full          (full[gi]),
                .empty         (empty[gi]),
                .fifo_count    (fifo_count[gi]),
                .overflow      (overflow[gi]),
                .busy          (busy[gi]),
                .done          (done[gi]),
                .transfere_data(line[gi])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: a word buffer plus a position inside the current frame.
    logic [DB-1:0] m_buf [NI][DEPTH];
    int            m_head [NI];
    int            m_cnt [NI];
    bit            m_active [NI];
    int            m_pos [NI];
    logic [DB-1:0] m_word [NI];
    bit            m_ovf [NI];
    bit            m_brkp [NI];
    bit            m_line [NI];
    bit            m_done [NI];

    function automatic int par_mode(input int i);
        return i;
    endfunction

    function automatic int stop_bits(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int flen(input int i);
        return (1 + DB + ((par_mode(i) != 0) ? 1 : 0) + stop_bits(i)) * CPB;
    endfunction

    function automatic bit frame_bit(input int i, input logic [DB-1:0] w, input int pos);
        int b;
        b = pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= DB) return w[b-1];
        if (par_mode(i) != 0 && b == DB + 1) return (par_mode(i) == 1) ? ^w : ~^w;
        return 1'b1;
    endfunction

    task automatic model_edge(input bit rst, input bit we, input logic [DB-1:0] d, input bit bk);
        for (int i = 0; i < NI; i++) begin
            bit full_b, was_idle;
            if (rst) begin
                m_head[i] = 0; m_cnt[i] = 0; m_active[i] = 0; m_pos[i] = 0;
                m_ovf[i] = 0; m_brkp[i] = 0; m_line[i] = 1; m_done[i] = 0;
                continue;
            end
            full_b   = (m_cnt[i] == DEPTH);
            was_idle = !m_active[i];
            if (m_active[i]) begin
                m_pos[i]++;
                if (m_pos[i] == flen(i)) m_active[i] = 0;
            end else if (m_cnt[i] > 0 && !bk && !m_brkp[i]) begin
                m_word[i]   = m_buf[i][m_head[i]];
                m_head[i]   = (m_head[i] + 1) % DEPTH;
                m_cnt[i]--;
                m_active[i] = 1;
                m_pos[i]    = 0;
            end
            if (we) begin
                if (full_b) m_ovf[i] = 1;
                else begin
                    m_buf[i][(m_head[i] + m_cnt[i]) % DEPTH] = d;
                    m_cnt[i]++;
                end
            end
            m_brkp[i] = bk;
            if (m_active[i]) m_line[i] = frame_bit(i, m_word[i], m_pos[i]);
            else             m_line[i] = !(was_idle && bk);
            m_done[i] = m_active[i] && (m_pos[i] == flen(i) - 1);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("line[%0d]", i),     32'(line[i]),       32'(m_line[i]));
            check($sformatf("done[%0d]", i),     32'(done[i]),       32'(m_done[i]));
            check($sformatf("busy[%0d]", i),     32'(busy[i]),       32'(m_active[i]));
            check($sformatf("count[%0d]", i),    32'(fifo_count[i]), 32'(m_cnt[i]));
            check($sformatf("full[%0d]", i),     32'(full[i]),       32'(m_cnt[i] == DEPTH));
            check($sformatf("empty[%0d]", i),    32'(empty[i]),      32'(m_cnt[i] == 0));
            check($sformatf("overflow[%0d]", i), 32'(overflow[i]),   32'(m_ovf[i]));
        end
    endtask

    task automatic cyc(input bit rst, input bit we, input logic [DB-1:0] d, input bit bk);
        @(negedge clk);
        Tx_rst  = rst;
        wr_en   = we;
        wr_data = d;
`ifdef UART_TX_BREAK_EN
        break_req = bk;
`endif
        @(posedge clk);
        model_edge(rst, we, d, bk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, $urandom_range(0, 255), 1'b0);
    endtask

    initial begin
        bit rbk;
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);

        // Single frames, including the parity example word.
        cyc(1'b0, 1'b1, 8'hA5, 1'b0);
        idle(55);
        cyc(1'b0, 1'b1, 8'h07, 1'b0);
        idle(55);

        // Burst of six pushes: first pops at once, sixth overflows.
        for (int w = 1; w <= 6; w++) cyc(1'b0, 1'b1, DB'(w), 1'b0);
        idle(300);

        // Reset during data bit 3 with words still queued.
        cyc(1'b0, 1'b1, 8'h3C, 1'b0);
        cyc(1'b0, 1'b1, 8'h5A, 1'b0);
        cyc(1'b0, 1'b1, 8'h99, 1'b0);
        idle(15);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        idle(60);

`ifdef UART_TX_BREAK_EN
        // Break held while a word is queued, then released.
        cyc(1'b0, 1'b1, 8'h55, 1'b1);
        for (int k = 0; k < 19; k++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        idle(60);
`endif

        // Randomised traffic with occasional resets (and breaks when enabled).
        rbk = 1'b0;
        for (int k = 0; k < 3000; k++) begin
`ifdef UART_TX_BREAK_EN
            if ($urandom_range(0, 79) == 0) rbk = !rbk;
`endif
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 5) == 0,
                DB'($urandom_range(0, 255)), rbk);
        end
        idle(200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
